ddram_arb: RTL

Two-requester arbiter for the shared DDR3 Avalon-MM burst interface of an `emu` core. Port 0 is a burst-read fetcher, such as a video or framebuffer line fetch; port 1 is a single-word read/write port, such as a CPU or loader. The block sits between those requesters and the top-level `DDRAM_*` pins. It serialises commands, holds them through `DDRAM_BUSY`, and routes returned read beats to the requester that issued the read.

---
 rtl/ddram_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ddram_arb.sv
// Two-port arbiter for the shared DDR3 Avalon-MM burst port: port 0 burst reads, port 1 single-word rd/wr.
// Define DDRAM_ARB_RR_EN for round-robin arbitration; default build is fixed priority with port 0 winning.
module ddram_arb #(
  parameter int P0_MAXBURST = 128
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic        p0_rd,
  input  logic [28:0] p0_addr,
  input  logic [7:0]  p0_burst,
  output logic        p0_ack,
  output logic [63:0] p0_dout,
  output logic        p0_dvalid,

  input  logic        p1_rd,
  input  logic        p1_we,
  input  logic [28:0] p1_addr,
  input  logic [63:0] p1_din,
  input  logic [7:0]  p1_be,
  output logic        p1_ack,
  output logic [63:0] p1_dout,
  output logic        p1_dvalid,

  input  logic        ddram_busy,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  output logic        ddram_rd,
  output logic        ddram_we,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be
);

  // state  | meaning
  // IDLE   | sample requests, register the winner's command
  // CMD    | command on the bus, held while ddram_busy
  // RDWAIT | route returned beats to the owner until the burst completes
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  localparam logic [7:0] MAX_LEN = 8'(P0_MAXBURST);

  state_t     state;
  logic       owner;
  logic [7:0] beats;
  logic [7:0] p0_len;
  logic       req1;
  logic       grant_any;
  logic       grant1;
  logic       cmd_done;

`ifdef DDRAM_ARB_RR_EN
  logic       rr_ptr;
`endif

  always_comb begin
    p0_len = p0_burst;
    if (p0_burst == 8'd0)
      p0_len = 8'd1;
    else if (p0_burst > MAX_LEN)
      p0_len = MAX_LEN;
  end

  assign req1      = p1_rd | p1_we;
  assign grant_any = p0_rd | req1;

`ifdef DDRAM_ARB_RR_EN
  // rr_ptr names the port preferred when both are requesting
  assign grant1 = req1 & (~p0_rd | rr_ptr);
`else
  assign grant1 = req1 & ~p0_rd;
`endif

  assign cmd_done = (state == CMD) && !ddram_busy;
  assign p0_ack   = cmd_done && !owner;
  assign p1_ack   = cmd_done && owner;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      beats          <= 8'd0;
      ddram_burstcnt <= 8'd0;
      ddram_addr     <= 29'd0;
      ddram_rd       <= 1'b0;
      ddram_we       <= 1'b0;
      ddram_din      <= 64'd0;
      ddram_be       <= 8'd0;
      p0_dout        <= 64'd0;
      p0_dvalid      <= 1'b0;
      p1_dout        <= 64'd0;
      p1_dvalid      <= 1'b0;
`ifdef DDRAM_ARB_RR_EN
      rr_ptr         <= 1'b0;
`endif
    end else begin
      p0_dvalid <= 1'b0;
      p1_dvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state <= CMD;
            if (grant1) begin
              // write wins a simultaneous rd+we; the read stays pending
              owner          <= 1'b1;
              ddram_addr     <= p1_addr;
              ddram_burstcnt <= 8'd1;
              ddram_rd       <= ~p1_we;
              ddram_we       <= p1_we;
              ddram_din      <= p1_din;
              ddram_be       <= p1_be;
            end else begin
              owner          <= 1'b0;
              ddram_addr     <= p0_addr;
              ddram_burstcnt <= p0_len;
              ddram_rd       <= 1'b1;
              ddram_we       <= 1'b0;
              ddram_be       <= 8'hFF;
            end
          end
        end

        CMD: begin
          if (!ddram_busy) begin
            ddram_rd <= 1'b0;
            ddram_we <= 1'b0;
`ifdef DDRAM_ARB_RR_EN
            rr_ptr   <= ~owner;
`endif
            if (ddram_rd) begin
              beats <= ddram_burstcnt;
              state <= RDWAIT;
            end else begin
              state <= IDLE;
            end
          end
        end

        RDWAIT: begin
          if (ddram_dout_ready) begin
            if (owner) begin
              p1_dout   <= ddram_dout;
              p1_dvalid <= 1'b1;
            end else begin
              p0_dout   <= ddram_dout;
              p0_dvalid <= 1'b1;
            end
            beats <= beats - 8'd1;
            if (beats <= 8'd1)
              state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
